// File: rtl/npu_mem_pkg.sv
// ---------------------------------------------------------------------------
// npu_mem_pkg
// Shared memory-subsystem package. This package holds the state encoding for
// the burst drain engine that moves words from a sync FIFO into a
// valid/ready stream.
// ---------------------------------------------------------------------------
package npu_mem_pkg;

  // IDLE : waiting for a full burst, or for a flush of a partial one
  // RUN  : issuing FIFO reads for the latched burst
  // DRAIN: every read is issued; waiting for the last beat to leave
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
// Two-entry output buffer for a valid/ready stream. Entries are written by
// push_i and leave in order when the consumer accepts them. The head entry
// does not change while it waits, so the output stays stable under
// back-pressure.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset (empties the buffer)
//   push_i       write data_i into the tail this cycle
//   data_i       entry to write
//   ready_i      consumer ready; the head leaves when valid_o & ready_i
//   valid_o      buffer holds at least one entry
//   data_o       head entry
//   count_o      current occupancy, 0..2
// ---------------------------------------------------------------------------
module stream_skid_buf #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wrPtr_q;
  logic             rdPtr_q;
  logic [1:0]       count_q;
  logic             pop;
  logic             doPush;

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign pop     = valid_o & ready_i;

  // If the buffer is full, a write is accepted only when a pop frees a slot
  // in the same cycle. The issue logic upstream should never need this, but
  // the guard keeps the buffer contents consistent.
  assign doPush  = push_i & ((count_q != 2'd2) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      case ({doPush, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_drain.sv
// ---------------------------------------------------------------------------
// fifo_burst_drain
// This block reads bursts of words out of an upstream sync FIFO and sends
// them on a valid/ready stream. A burst normally starts when the FIFO holds
// BURST_LEN words. A flush request drains whatever is left as a shorter
// burst. The final beat of each burst is marked with m_last. The FIFO has a
// one-cycle read latency, and reads are throttled so the returned data always
// fits in a two-entry output buffer.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   fifo_rd_en     read strobe to the FIFO
//   fifo_rd_data   FIFO data, valid the cycle after an accepted read
//   fifo_empty     FIFO empty flag
//   fifo_count     FIFO occupancy
//   flush          level request to drain a partial burst
//   m_valid/m_ready/m_data/m_last   output stream
//   busy           high whenever the engine is not IDLE
// ---------------------------------------------------------------------------
module fifo_burst_drain
  import npu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
  input  logic                       fifo_empty,
  input  logic [$clog2(DEPTH):0]     fifo_count,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_last,
  output logic                       busy
);

  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  BurstLenC = CW'(BURST_LEN);
  localparam logic [CW-1:0]  OneC      = CW'(1);

  drain_state_e    state_q, state_d;
  logic [CW-1:0]   burstLen_q, burstLen_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic            inflight_q;
  logic            inflightLast_q;

  logic            issue;
  logic            issueLast;
  logic            spaceOk;
  logic            pop;
  logic            bufValid;
  logic [1:0]      bufCount;
  logic [DATA_WIDTH:0] bufData;

  assign pop       = bufValid & m_ready;
  assign issueLast = ((issued_q + OneC) == burstLen_q);

  // A new read is allowed only if its data will have a slot when it returns.
  // That means the beats already buffered, plus the read in flight, minus the
  // beat leaving this cycle, must be fewer than two.
  assign spaceOk = ({1'b0, bufCount} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_d    = state_q;
    burstLen_d = burstLen_q;
    issued_d   = issued_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        // The count != 0 guard prevents a zero-length burst if the FIFO
        // flags ever disagree for a cycle.
        if (fifo_count >= BurstLenC) begin
          state_d    = RUN;
          burstLen_d = BurstLenC;
          issued_d   = '0;
        end else if (flush && !fifo_empty && (fifo_count != '0)) begin
          state_d    = RUN;
          burstLen_d = fifo_count;
          issued_d   = '0;
        end
      end
      RUN: begin
        if ((issued_q < burstLen_q) && !fifo_empty && spaceOk) begin
          issue    = 1'b1;
          issued_d = issued_q + OneC;
          if (issueLast) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && bufData[DATA_WIDTH]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears the in-flight flag, so a read that returns after reset is
  // never pushed into the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      burstLen_q     <= '0;
      issued_q       <= '0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      burstLen_q     <= burstLen_d;
      issued_q       <= issued_d;
      inflight_q     <= issue;
      inflightLast_q <= issue & issueLast;
    end
  end

  // Each buffer entry holds the data word plus its last flag in the MSB.
  stream_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  ({inflightLast_q, fifo_rd_data}),
    .ready_i (m_ready),
    .valid_o (bufValid),
    .data_o  (bufData),
    .count_o (bufCount)
  );

  assign fifo_rd_en = issue;
  assign m_valid    = bufValid;
  assign m_data     = bufData[DATA_WIDTH-1:0];
  assign m_last     = bufValid & bufData[DATA_WIDTH];
  assign busy       = (state_q != IDLE);

endmodule
